// File: rtl/munoc_ahb_master_bridge.sv
// rtl/munoc_ahb_master_bridge.sv - AHB-Lite slave port to single-beat AXI read/write requests
// Each accepted AHB beat becomes one non-posted AXI transaction; the data phase stalls until the response.
module munoc_ahb_master_bridge #(
  parameter int BW_PLATFORM_ADDR = 32,
  parameter int BW_NODE_DATA     = 32
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          comm_disable,
  input  logic                          hsel,
  input  logic                          hready,
  input  logic                          hwrite,
  input  logic [BW_PLATFORM_ADDR-1:0]   haddr,
  input  logic [1:0]                    htrans,
  input  logic [2:0]                    hsize,
  input  logic [2:0]                    hburst,
  input  logic [BW_NODE_DATA-1:0]       hwdata,
  output logic                          hreadyout,
  output logic                          hresp,
  output logic [BW_NODE_DATA-1:0]       hrdata,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [BW_PLATFORM_ADDR-1:0]   awaddr,
  output logic [2:0]                    awsize,
  output logic [7:0]                    awlen,
  output logic [1:0]                    awburst,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [BW_NODE_DATA-1:0]       wdata,
  output logic [BW_NODE_DATA/8-1:0]     wstrb,
  output logic                          wlast,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [1:0]                    bresp,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [BW_PLATFORM_ADDR-1:0]   araddr,
  output logic [2:0]                    arsize,
  output logic [7:0]                    arlen,
  output logic [1:0]                    arburst,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [1:0]                    rresp,
  input  logic [BW_NODE_DATA-1:0]       rdata
);

  localparam int SW   = BW_NODE_DATA / 8;
  localparam int LOG2 = $clog2(SW);

  typedef enum logic [2:0] {
    S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RRESP, S_ERR1, S_ERR2
  } state_t;

  state_t                      state;
  logic [BW_PLATFORM_ADDR-1:0] addr_q;
  logic [2:0]                  size_q;
  logic                        accept;
  logic                        accept_err;
  logic                        aw_done;
  logic                        w_done;
  int                          lane_off;
  int                          lane_cnt;
  logic                        unused_inputs;

  assign unused_inputs = ^{htrans[0], hburst, bresp[0], rresp[0]};

  assign accept     = hsel & htrans[1] & hready & ((state == S_IDLE) | (state == S_ERR2));
  assign accept_err = comm_disable | (hsize > 3'(LOG2));

  // A channel counts as done once its valid has dropped or is handshaking this cycle.
  assign aw_done = ~awvalid | awready;
  assign w_done  = ~wvalid | wready;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awsize  = size_q;
  assign arsize  = size_q;
  assign awlen   = 8'd0;
  assign arlen   = 8'd0;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wlast   = 1'b1;
  assign wdata   = hwdata;

  // Byte lanes start at the address offset aligned down to the transfer size.
  always_comb begin
    lane_cnt = 1 << size_q;
    lane_off = int'(addr_q[LOG2-1:0]) & ~(lane_cnt - 1);
    wstrb    = '0;
    for (int i = 0; i < SW; i++) begin
      wstrb[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          if (accept) begin
            addr_q    <= haddr;
            size_q    <= hsize;
            hreadyout <= 1'b0;
            if (accept_err) begin
              state <= S_ERR1;
              hresp <= 1'b1;
            end else if (hwrite) begin
              state   <= S_WREQ;
              hresp   <= 1'b0;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= S_RREQ;
              hresp   <= 1'b0;
              arvalid <= 1'b1;
            end
          end else begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
        S_WREQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state  <= S_WRESP;
            bready <= 1'b1;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp[1]) begin
              state <= S_ERR1;
              hresp <= 1'b1;
            end else begin
              state     <= S_IDLE;
              hreadyout <= 1'b1;
            end
          end
        end
        S_RREQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (rvalid) begin
            rready <= 1'b0;
            hrdata <= rdata;
            if (rresp[1]) begin
              state <= S_ERR1;
              hresp <= 1'b1;
            end else begin
              state     <= S_IDLE;
              hreadyout <= 1'b1;
            end
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_munoc_ahb_master_bridge.sv
// tb/tb_munoc_ahb_master_bridge.sv - directed bench for the AHB-to-AXI master bridge
module tb_munoc_ahb_master_bridge;

  logic        clk = 1'b0;
  logic        rstnn, comm_disable, hsel, hready, hwrite;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        hreadyout, hresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  munoc_ahb_master_bridge #(.BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32)) dut (
    .clk(clk), .rstnn(rstnn), .comm_disable(comm_disable),
    .hsel(hsel), .hready(hready), .hwrite(hwrite), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
  );

  // AXI slave model: each ready/valid rises after its programmed number of extra cycles.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = 32'h0;

  always @(negedge clk) begin
    if (awvalid) begin aw_wait++; awready = (aw_wait > aw_delay); end else begin aw_wait = 0; awready = 1'b0; end
    if (wvalid)  begin w_wait++;  wready  = (w_wait > w_delay);   end else begin w_wait = 0;  wready = 1'b0;  end
    if (arvalid) begin ar_wait++; arready = (ar_wait > ar_delay); end else begin ar_wait = 0; arready = 1'b0; end
    if (bready)  begin b_wait++;  bvalid  = (b_wait > b_delay);   end else begin b_wait = 0;  bvalid = 1'b0;  end
    if (rready)  begin r_wait++;  rvalid  = (r_wait > r_delay);   end else begin r_wait = 0;  rvalid = 1'b0;  end
    bresp = bresp_val;
    rresp = rresp_val;
    rdata = rdata_val;
  end

  int          cyc = 0, aw_beats = 0, w_beats = 0, ar_beats = 0;
  int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
  logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
  logic [2:0]  cap_awsize, cap_arsize;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;
  byte         ev_q[$];

  always @(posedge clk) begin
    cyc++;
    if (awvalid) aw_vcyc++;
    if (wvalid)  w_vcyc++;
    if (arvalid) ar_vcyc++;
    if (awvalid && awready) begin aw_beats++; cap_awaddr = awaddr; cap_awsize = awsize; ev_q.push_back(8'h41); end
    if (wvalid && wready) begin w_beats++; cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; ev_q.push_back(8'h57); end
    if (arvalid && arready) begin ar_beats++; cap_araddr = araddr; cap_arsize = arsize; ev_q.push_back(8'h52); end
  end

  // Address phase, then count stalled data-phase cycles until hreadyout returns.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wd, output int waits, output logic err, output logic [31:0] rd);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0; err = 1'b0;
    while (hreadyout !== 1'b1 && waits < 40) begin
      if (hresp === 1'b1) err = 1'b1;
      waits++;
      @(posedge clk); #1;
    end
    if (hresp === 1'b1) err = 1'b1;
    rd = hrdata;
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (hreadyout !== 1'b1) begin miscompares++; $display("FAIL rst_hreadyout: got %b want 1", hreadyout); end
    vectors++; if (hresp !== 1'b0) begin miscompares++; $display("FAIL rst_hresp: got %b want 0", hresp); end
    vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("FAIL rst_hrdata: got %h want 0", hrdata); end
    vectors++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin miscompares++; $display("FAIL rst_valids: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    vectors++; if (awaddr !== 32'h0 || awsize !== 3'd0) begin miscompares++; $display("FAIL rst_addr: got %h/%0d want 0/0", awaddr, awsize); end
    vectors++; if (awlen !== 8'd0 || arlen !== 8'd0 || awburst !== 2'b01 || arburst !== 2'b01 || wlast !== 1'b1) begin
      miscompares++; $display("FAIL const_fields: got len %0d/%0d burst %0d/%0d wlast %b want 0/0 1/1 1", awlen, arlen, awburst, arburst, wlast); end
    rstnn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_write();
    int w; logic e; logic [31:0] r; int a0;
    a0 = aw_beats;
    ahb_xfer(1'b1, 32'h1000, 3'd2, 32'hDEADBEEF, w, e, r);
    vectors++; if (w !== 2) begin miscompares++; $display("FAIL word_wr_waits: got %0d want 2", w); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL word_wr_resp: got %b want 0", e); end
    vectors++; if (aw_beats - a0 !== 1) begin miscompares++; $display("FAIL word_wr_beats: got %0d want 1", aw_beats - a0); end
    vectors++; if (cap_awaddr !== 32'h1000 || cap_awsize !== 3'd2) begin miscompares++; $display("FAIL word_wr_aw: got %h/%0d want 1000/2", cap_awaddr, cap_awsize); end
    vectors++; if (cap_wstrb !== 4'hF || cap_wdata !== 32'hDEADBEEF || cap_wlast !== 1'b1) begin
      miscompares++; $display("FAIL word_wr_w: got %h/%h/%b want f/deadbeef/1", cap_wstrb, cap_wdata, cap_wlast); end
  endtask

  task automatic test_narrow_write();
    int w; logic e; logic [31:0] r;
    ahb_xfer(1'b1, 32'h1003, 3'd0, 32'hAB000000, w, e, r);
    vectors++; if (cap_wstrb !== 4'h8 || cap_wdata !== 32'hAB000000) begin miscompares++; $display("FAIL byte_wr: got %h/%h want 8/ab000000", cap_wstrb, cap_wdata); end
    ahb_xfer(1'b1, 32'h1002, 3'd1, 32'h5A5A0000, w, e, r);
    vectors++; if (cap_wstrb !== 4'hC) begin miscompares++; $display("FAIL half_wr: got %h want c", cap_wstrb); end
    ahb_xfer(1'b1, 32'h1001, 3'd1, 32'h00003C3C, w, e, r);
    vectors++; if (cap_wstrb !== 4'h3 || cap_awaddr !== 32'h1001) begin miscompares++; $display("FAIL half_unaligned: got %h/%h want 3/1001", cap_wstrb, cap_awaddr); end
  endtask

  task automatic test_read_delay();
    int w; logic e; logic [31:0] r; int a0;
    a0 = ar_beats; ar_delay = 3; rdata_val = 32'h12345678;
    ahb_xfer(1'b0, 32'h2004, 3'd2, 32'h0, w, e, r);
    ar_delay = 0;
    vectors++; if (w !== 5) begin miscompares++; $display("FAIL rd_waits: got %0d want 5", w); end
    vectors++; if (r !== 32'h12345678 || e !== 1'b0) begin miscompares++; $display("FAIL rd_data: got %h/%b want 12345678/0", r, e); end
    vectors++; if (ar_beats - a0 !== 1 || cap_araddr !== 32'h2004 || cap_arsize !== 3'd2) begin
      miscompares++; $display("FAIL rd_ar: got %0d beats %h/%0d want 1 2004/2", ar_beats - a0, cap_araddr, cap_arsize); end
  endtask

  task automatic test_resp_errors();
    int w; logic e; logic [31:0] r;
    bresp_val = 2'b10;
    ahb_xfer(1'b1, 32'h1000, 3'd2, 32'h1, w, e, r);
    bresp_val = 2'b00;
    vectors++; if (w !== 3 || e !== 1'b1) begin miscompares++; $display("FAIL bresp_err: got %0d/%b want 3/1", w, e); end
    vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin miscompares++; $display("FAIL err2_state: got %b/%b want 1/1", hreadyout, hresp); end
    @(posedge clk); #1;
    vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin miscompares++; $display("FAIL err_to_idle: got %b/%b want 1/0", hreadyout, hresp); end
    rresp_val = 2'b10; rdata_val = 32'hCAFEF00D;
    ahb_xfer(1'b0, 32'h2000, 3'd2, 32'h0, w, e, r);
    rresp_val = 2'b00;
    vectors++; if (w !== 3 || e !== 1'b1 || r !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rresp_err: got %0d/%b/%h want 3/1/cafef00d", w, e, r); end
    @(posedge clk); #1;
  endtask

  task automatic test_accept_errors();
    int w; logic e; logic [31:0] r; int av0, wv0, arv0, a0;
    av0 = aw_vcyc; wv0 = w_vcyc; arv0 = ar_vcyc;
    ahb_xfer(1'b1, 32'h1000, 3'd3, 32'h1, w, e, r);
    vectors++; if (w !== 1 || e !== 1'b1) begin miscompares++; $display("FAIL size_err: got %0d/%b want 1/1", w, e); end
    comm_disable = 1'b1;
    ahb_xfer(1'b0, 32'h2000, 3'd2, 32'h0, w, e, r);
    comm_disable = 1'b0;
    vectors++; if (w !== 1 || e !== 1'b1) begin miscompares++; $display("FAIL disable_err: got %0d/%b want 1/1", w, e); end
    vectors++; if (aw_vcyc != av0 || w_vcyc != wv0 || ar_vcyc != arv0) begin
      miscompares++; $display("FAIL err_no_axi: got %0d/%0d/%0d valid cycles want 0/0/0", aw_vcyc - av0, w_vcyc - wv0, ar_vcyc - arv0); end
    a0 = aw_beats;
    ahb_xfer(1'b1, 32'h1010, 3'd2, 32'h77, w, e, r);
    vectors++; if (w !== 2 || e !== 1'b0 || aw_beats - a0 !== 1 || cap_awaddr !== 32'h1010) begin
      miscompares++; $display("FAIL accept_in_err2: got %0d/%b/%0d/%h want 2/0/1/1010", w, e, aw_beats - a0, cap_awaddr); end
    ahb_xfer(1'b0, 32'h2000, 3'd3, 32'h0, w, e, r);
    arv0 = ar_vcyc;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (ar_vcyc != arv0 || hresp !== 1'b0 || hreadyout !== 1'b1) begin
      miscompares++; $display("FAIL cancel_in_err2: got %0d/%b/%b want 0/0/1", ar_vcyc - arv0, hresp, hreadyout); end
  endtask

  task automatic test_back_to_back();
    int w1, w2, t0, av0, wv0; logic e; logic [31:0] r; logic [23:0] seq;
    ev_q.delete(); aw_delay = 2; rdata_val = 32'h55AA55AA;
    av0 = aw_vcyc; wv0 = w_vcyc; t0 = cyc;
    ahb_xfer(1'b1, 32'h3000, 3'd2, 32'h11223344, w1, e, r);
    ahb_xfer(1'b0, 32'h3008, 3'd2, 32'h0, w2, e, r);
    aw_delay = 0;
    vectors++; if (w1 !== 4 || w2 !== 2) begin miscompares++; $display("FAIL b2b_waits: got %0d/%0d want 4/2", w1, w2); end
    vectors++; if (cyc - t0 !== 8) begin miscompares++; $display("FAIL b2b_cycles: got %0d want 8", cyc - t0); end
    vectors++; if (r !== 32'h55AA55AA) begin miscompares++; $display("FAIL b2b_rdata: got %h want 55aa55aa", r); end
    vectors++; if (aw_vcyc - av0 !== 3 || w_vcyc - wv0 !== 1) begin
      miscompares++; $display("FAIL b2b_valid_cycles: got %0d/%0d want 3/1", aw_vcyc - av0, w_vcyc - wv0); end
    seq = 24'h0;
    foreach (ev_q[i]) seq = {seq[15:0], ev_q[i]};
    vectors++; if (ev_q.size() !== 3 || seq !== 24'h574152) begin
      miscompares++; $display("FAIL b2b_order: got %0d beats %h want 3 574152", ev_q.size(), seq); end
  endtask

  task automatic test_reset_mid();
    int w; logic e; logic [31:0] r; int a0;
    a0 = ar_beats; ar_delay = 10;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h4000; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL mid_pending: got %b want 1", arvalid); end
    rstnn = 1'b0;
    @(posedge clk); #1;
    vectors++; if (arvalid !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: got %b/%b/%b want 0/1/0", arvalid, hreadyout, hresp); end
    rstnn = 1'b1; ar_delay = 0; rdata_val = 32'h0BADF00D;
    @(posedge clk); #1;
    ahb_xfer(1'b0, 32'h4004, 3'd2, 32'h0, w, e, r);
    vectors++; if (w !== 2 || r !== 32'h0BADF00D || ar_beats - a0 !== 1) begin
      miscompares++; $display("FAIL after_reset_rd: got %0d/%h/%0d want 2/0badf00d/1", w, r, ar_beats - a0); end
  endtask

  initial begin
    rstnn = 1'b0; comm_disable = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = 32'h0;
    htrans = 2'b00; hsize = 3'd0; hburst = 3'd0; hwdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    test_reset();
    test_word_write();
    test_narrow_write();
    test_read_delay();
    test_resp_errors();
    test_accept_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
